// File: rtl/tamagotchi_fsm.sv
// Virtual-pet core. Four needs (salud, energia, hambre, diversion), each a
// 0..5 level. Buttons select or feed a need, levels decay over time, and the
// current state code plus a 7-segment digit are driven out registered.

// Next level of one need: a feed takes precedence over a decay tick that
// lands on the same cycle. Both directions saturate.
module tamagotchi_need #(
  parameter logic [2:0] MAX_LEVEL = 3'd5
) (
  input  logic [2:0] lvl_i,
  input  logic       feed_i,
  input  logic       decay_i,
  output logic [2:0] lvl_o
);

  // Saturating +1 on feed, otherwise saturating -1 on decay.
  always_comb begin
    lvl_o = lvl_i;
    if (feed_i) begin
      if (lvl_i < MAX_LEVEL) lvl_o = lvl_i + 3'd1;
    end else if (decay_i) begin
      if (lvl_i != 3'd0) lvl_o = lvl_i - 3'd1;
    end
  end

endmodule

module tamagotchi_fsm #(
  parameter int unsigned DECAY_CYCLES      = 50_000_000,
  parameter int unsigned TEST_DECAY_CYCLES = 8,
  parameter int unsigned IDLE_TIMEOUT      = 250_000_000,
  parameter logic [2:0]  HOLD_COUNT        = 3'd5,
  parameter logic [2:0]  INIT_LEVEL        = 3'd3
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       btn_salud,
  input  logic       btn_energia,
  input  logic       btn_hambre,
  input  logic       btn_diversion,
  input  logic       btn_test,
  input  logic [2:0] count_reset,
  input  logic [2:0] count_test,
  output logic [2:0] display_out,
  output logic [6:0] seg_display
);

  localparam int NUM_NEEDS = 4;
  localparam int NUM_BTNS  = NUM_NEEDS + 1;  // needs in [3:0], test in [4]
  localparam int DCW       = $clog2(DECAY_CYCLES);
  localparam int ICW       = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [DCW-1:0] DEC_LAST = DCW'(DECAY_CYCLES - 1);
  localparam logic [DCW-1:0] TST_LAST = DCW'(TEST_DECAY_CYCLES - 1);
  localparam logic [ICW-1:0] IDLE_MAX = ICW'(IDLE_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_SALUD     = 3'b001,
    S_ENERGIA   = 3'b010,
    S_HAMBRE    = 3'b011,
    S_DIVERSION = 3'b100,
    S_ALERT     = 3'b111
  } state_e;

  function automatic logic [6:0] seg_of(input logic [2:0] v);
    case (v)
      3'd0:    seg_of = 7'b0111111;
      3'd1:    seg_of = 7'b0000110;
      3'd2:    seg_of = 7'b1011011;
      3'd3:    seg_of = 7'b1001111;
      3'd4:    seg_of = 7'b1100110;
      3'd5:    seg_of = 7'b1101101;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  // ---------------- reset release synchronizer ----------------
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Assert asynchronously, release two clocks after btn_reset rises.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) rst_sync_q <= '0;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // ---------------- button synchronizers + edge detect ----------------
  logic [NUM_BTNS-1:0] btn_raw, sync1_q, sync2_q, prev_q, press;
  logic [1:0]          vld_pipe;  // [1] set once sync2_q holds a real sample

  assign btn_raw = {btn_test, btn_diversion, btn_hambre, btn_energia, btn_salud};

  // prev_q is held at 1 until the chain is filled, so a button held through
  // reset release is seen as already-pressed rather than as a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '1;
      vld_pipe <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      prev_q   <= vld_pipe[1] ? sync2_q : '1;
      vld_pipe <= {vld_pipe[0], 1'b1};
    end
  end
  assign press = vld_pipe[1] ? (sync2_q & ~prev_q) : '0;

  // ---------------- registered state ----------------
  state_e                     state_q, state_d;
  logic [NUM_NEEDS-1:0][2:0]  lvl_q, lvl_d, lvl_nx;
  logic [6:0]                 seg_q, seg_d;
  logic                       test_q, test_d;
  logic [DCW-1:0]             dec_cnt_q, dec_cnt_d;
  logic [ICW-1:0]             idle_cnt_q, idle_cnt_d;

  // ---------------- press decode ----------------
  logic                 press_any, sel_q, test_toggle, decay_tick, soft_rst;
  logic [1:0]           press_idx, cur_idx;
  logic [NUM_NEEDS-1:0] feed;

  assign press_any   = |press[NUM_NEEDS-1:0];
  assign sel_q       = (state_q != S_IDLE) && (state_q != S_ALERT);
  assign cur_idx     = 2'(state_q - 3'd1);
  assign soft_rst    = (count_reset >= HOLD_COUNT);
  assign test_toggle = press[NUM_BTNS-1] && (count_test >= HOLD_COUNT);
  assign decay_tick  = (dec_cnt_q == (test_q ? TST_LAST : DEC_LAST)) && !test_toggle;

  // Fixed priority salud > energia > hambre > diversion.
  always_comb begin
    press_idx = 2'd3;
    if      (press[0]) press_idx = 2'd0;
    else if (press[1]) press_idx = 2'd1;
    else if (press[2]) press_idx = 2'd2;
  end

  for (genvar g = 0; g < NUM_NEEDS; g++) begin : g_need
    assign feed[g] = press_any && sel_q && (press_idx == 2'(g)) && (cur_idx == 2'(g));
    tamagotchi_need u_need (
      .lvl_i   (lvl_q[g]),
      .feed_i  (feed[g]),
      .decay_i (decay_tick),
      .lvl_o   (lvl_nx[g])
    );
  end

  // Next state, levels, counters and the digit to display.
  always_comb begin
    logic       new_sel, any_zero, timeout;
    logic [1:0] new_idx;
    logic [2:0] lvl_min, shown;

    lvl_d      = lvl_nx;
    test_d     = test_q ^ test_toggle;
    dec_cnt_d  = (decay_tick || test_toggle) ? '0 : dec_cnt_q + DCW'(1);
    idle_cnt_d = press_any ? '0 :
                 (idle_cnt_q == IDLE_MAX) ? IDLE_MAX : idle_cnt_q + ICW'(1);
    timeout    = (idle_cnt_d == IDLE_MAX);

    new_sel = sel_q;
    new_idx = cur_idx;
    if (press_any) begin
      new_sel = 1'b1;
      new_idx = press_idx;
    end else if (timeout) begin
      new_sel = 1'b0;
    end

    if (soft_rst) begin
      lvl_d      = {NUM_NEEDS{INIT_LEVEL}};
      test_d     = 1'b0;
      dec_cnt_d  = '0;
      idle_cnt_d = '0;
      new_sel    = 1'b0;
    end

    any_zero = 1'b0;
    lvl_min  = lvl_d[0];
    for (int i = 0; i < NUM_NEEDS; i++) begin
      if (lvl_d[i] == 3'd0)   any_zero = 1'b1;
      if (lvl_d[i] < lvl_min) lvl_min  = lvl_d[i];
    end

    state_d = new_sel ? state_e'({1'b0, new_idx} + 3'd1)
                      : (any_zero ? S_ALERT : S_IDLE);
    shown   = new_sel ? lvl_d[new_idx] : lvl_min;
    seg_d   = seg_of(shown);
  end

  // Pet state registers; outputs come straight from these flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lvl_q      <= {NUM_NEEDS{INIT_LEVEL}};
      seg_q      <= seg_of(INIT_LEVEL);
      test_q     <= 1'b0;
      dec_cnt_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      seg_q      <= seg_d;
      test_q     <= test_d;
      dec_cnt_q  <= dec_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign display_out = state_q;
  assign seg_display = seg_q;

endmodule

// File: tb/tb_tamagotchi_fsm.sv
// Directed bench for tamagotchi_fsm: expected outputs go into a scoreboard
// queue as each step is driven and are popped when the DUT result is sampled.
module tb_tamagotchi_fsm;

  logic       clk = 1'b0;
  logic       btn_reset, btn_salud, btn_energia, btn_hambre, btn_diversion, btn_test;
  logic [2:0] count_reset, count_test;
  logic [2:0] display_out;
  logic [6:0] seg_display;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tamagotchi_fsm #(.IDLE_TIMEOUT(200)) dut (
    .clk           (clk),
    .btn_reset     (btn_reset),
    .btn_salud     (btn_salud),
    .btn_energia   (btn_energia),
    .btn_hambre    (btn_hambre),
    .btn_diversion (btn_diversion),
    .btn_test      (btn_test),
    .count_reset   (count_reset),
    .count_test    (count_test),
    .display_out   (display_out),
    .seg_display   (seg_display)
  );

  localparam logic [6:0] SEG0 = 7'b0111111;
  localparam logic [6:0] SEG1 = 7'b0000110;
  localparam logic [6:0] SEG2 = 7'b1011011;
  localparam logic [6:0] SEG3 = 7'b1001111;
  localparam logic [6:0] SEG4 = 7'b1100110;
  localparam logic [6:0] SEG5 = 7'b1101101;

  localparam logic [4:0] B_SAL = 5'b00001;
  localparam logic [4:0] B_ENE = 5'b00010;
  localparam logic [4:0] B_HAM = 5'b00100;
  localparam logic [4:0] B_DIV = 5'b01000;
  localparam logic [4:0] B_TST = 5'b10000;

  typedef struct {
    string      tag;
    logic [2:0] disp;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push(input string tag, input logic [2:0] d, input logic [6:0] s);
    exp_t e;
    e.tag  = tag;
    e.disp = d;
    e.seg  = s;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    vectors++;
    assert (display_out === e.disp) else begin
      miscompares++;
      $error("FAIL %s display_out got %b expected %b", e.tag, display_out, e.disp);
    end
    vectors++;
    assert (seg_display === e.seg) else begin
      miscompares++;
      $error("FAIL %s seg_display got %b expected %b", e.tag, seg_display, e.seg);
    end
  endtask

  // One-clock press starting at the current negedge; result sampled after
  // the third rising edge.
  task automatic press(input logic [4:0] m, input logic [2:0] ct, input string tag,
                       input logic [2:0] d, input logic [6:0] s);
    push(tag, d, s);
    count_test = ct;
    {btn_test, btn_diversion, btn_hambre, btn_energia, btn_salud} = m;
    @(negedge clk);
    {btn_test, btn_diversion, btn_hambre, btn_energia, btn_salud} = '0;
    @(negedge clk);
    @(negedge clk);
    check_out();
    count_test = 3'd0;
  endtask

  task automatic idle_to(input int target, input string tag,
                         input logic [2:0] d, input logic [6:0] s);
    push(tag, d, s);
    while (cyc < target) @(negedge clk);
    check_out();
  endtask

  task automatic soft_reset(input string tag);
    push(tag, 3'b000, SEG3);
    count_reset = 3'd5;
    @(negedge clk);
    count_reset = 3'd0;
    check_out();
  endtask

  initial begin
    int t, p;
    {btn_test, btn_diversion, btn_hambre, btn_energia, btn_salud} = '0;
    count_reset = 3'd0;
    count_test  = 3'd0;
    btn_reset   = 1'b1;
    #2 btn_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    push("reset_hold", 3'b000, SEG3);
    check_out();
    btn_reset = 1'b1;
    repeat (6) @(negedge clk);
    push("reset_release", 3'b000, SEG3);
    check_out();

    // select, feed, saturate
    press(B_SAL, 3'd0, "salud_select", 3'b001, SEG3);
    press(B_SAL, 3'd0, "salud_feed1",  3'b001, SEG4);
    press(B_SAL, 3'd0, "salud_feed2",  3'b001, SEG5);
    press(B_SAL, 3'd0, "salud_sat",    3'b001, SEG5);

    // switch and priority
    press(B_DIV,         3'd0, "div_switch",   3'b100, SEG3);
    press(B_ENE | B_HAM, 3'd0, "prio_ene_ham", 3'b010, SEG3);

    // short test press ignored, long one enters test mode
    press(B_TST, 3'd2, "test_short", 3'b010, SEG3);
    press(B_TST, 3'd5, "test_on",    3'b010, SEG3);
    t = cyc;
    idle_to(t + 8,  "decay_one",   3'b010, SEG2);
    idle_to(t + 24, "decay_three", 3'b010, SEG0);

    // soft reset restores levels and leaves test mode
    soft_reset("soft_reset");
    t = cyc;
    idle_to(t + 24, "normal_rate", 3'b000, SEG3);

    // decay with nothing selected: min level shown, then ALERT at zero
    press(B_TST, 3'd5, "test_on2", 3'b000, SEG3);
    t = cyc;
    idle_to(t + 16, "idle_min",     3'b000, SEG1);
    idle_to(t + 23, "idle_min_end", 3'b000, SEG1);
    idle_to(t + 24, "alert",        3'b111, SEG0);

    // feed colliding with a decay tick
    soft_reset("soft_reset2");
    press(B_TST, 3'd5, "test_on3", 3'b000, SEG3);
    t = cyc;
    press(B_SAL, 3'd0, "coll_select", 3'b001, SEG3);
    while (((cyc + 3 - t) % 8) != 0) @(negedge clk);
    press(B_SAL, 3'd0, "coll_feed",  3'b001, SEG4);
    press(B_ENE, 3'd0, "coll_ene",   3'b010, SEG2);
    press(B_HAM, 3'd0, "coll_ham",   3'b011, SEG2);
    p = cyc;
    idle_to(t + 16,  "coll_tick",     3'b011, SEG1);

    // idle timeout drops the selection; all levels are 0 by then
    idle_to(p + 199, "timeout_pre",   3'b011, SEG0);
    idle_to(p + 200, "timeout_alert", 3'b111, SEG0);

    // reset asserted mid-press, button held through release
    btn_salud = 1'b1;
    @(negedge clk);
    btn_reset = 1'b0;
    #1;
    push("async_reset", 3'b000, SEG3);
    check_out();
    @(negedge clk);
    @(negedge clk);
    btn_reset = 1'b1;
    repeat (10) @(negedge clk);
    push("held_release", 3'b000, SEG3);
    check_out();
    btn_salud = 1'b0;
    repeat (4) @(negedge clk);
    push("btn_release", 3'b000, SEG3);
    check_out();
    press(B_SAL, 3'd0, "post_reset_press", 3'b001, SEG3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tamagotchi_fsm.md
Name: tamagotchi_fsm

Overview:
- Virtual-pet core with four needs: salud, energia, hambre and diversion. Each need is held as a level from 0 to 5.
- Button presses select a need; repeated presses on the same need feed it.
- Levels decay over time. Decay is faster in test mode.
- Sits between the debounced board buttons (plus their external hold-time counters) and the 7-segment/indicator display.

Parameters:
- DECAY_CYCLES, 50_000_000, normal-mode clocks between decay ticks.
- TEST_DECAY_CYCLES, 8, test-mode clocks between decay ticks.
- IDLE_TIMEOUT, 250_000_000, clocks without a press before returning to IDLE.
- HOLD_COUNT, 3'd5, count_test/count_reset value that qualifies a long press.
- INIT_LEVEL, 3'd3, level of every need after reset.

Ports:
- clk  in  1  system clock, rising edge.
- btn_reset  in  1  asynchronous active-low reset.
- btn_salud  in  1  health button, active high.
- btn_energia  in  1  energy button, active high.
- btn_hambre  in  1  hunger button, active high.
- btn_diversion  in  1  fun button, active high.
- btn_test  in  1  test-mode button, active high.
- count_reset  in  3  external hold-time count of the reset button.
- count_test  in  3  external hold-time count of the test button.
- display_out  out  3  current state code.
- seg_display  out  7  7-segment pattern, active high, bit order {g,f,e,d,c,b,a}.

Behaviour:
- Input path:
  - Each button passes a 2-FF synchronizer, then a rising-edge detector that produces a 1-clk press pulse.
  - A high pulse of at least 1 clk is always captured.
- Latency: state, level and output registers update on the 3rd rising edge after a button is first sampled high. Outputs are registered.
- States and display_out codes:
  - IDLE=000, SALUD=001, ENERGIA=010, HAMBRE=011, DIVERSION=100.
  - ALERT=111: IDLE while any need is at 0.
- Press rules:
  - Press of need X while the state is not X: state becomes X; the level is unchanged.
  - Press of need X while the state is X: level_X += 1, saturating at 5.
  - Simultaneous presses: priority salud > energia > hambre > diversion; lower-priority presses are ignored.
- Idle timeout:
  - An inactivity counter clears on any need press.
  - When it reaches IDLE_TIMEOUT, the state returns to IDLE, or to ALERT if any level is 0.
- Decay:
  - A free-running counter wraps at DECAY_CYCLES-1, or at TEST_DECAY_CYCLES-1 in test mode.
  - On wrap, every level is decremented, saturating at 0.
  - If a feed and a decay tick land on the same cycle, the fed need gets +1 only; the other needs decay.
- ALERT/IDLE resolution: whenever no need is selected, the state is ALERT if any level is 0, otherwise IDLE. It is re-evaluated every cycle.
- seg_display:
  - In a need state it shows that need's level; in IDLE/ALERT it shows the minimum of the four levels.
  - Digit patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101. Any other value shows 0000000.
- Test mode:
  - Toggled by a btn_test press pulse only when count_test >= HOLD_COUNT at that cycle.
  - Shorter presses are ignored.
  - Changing mode clears the decay counter.
- Soft reset: while count_reset >= HOLD_COUNT, all levels go to INIT_LEVEL, the state goes to IDLE, test mode clears and counters clear, synchronously.
- Asynchronous reset (btn_reset=0):
  - Levels = INIT_LEVEL, state = IDLE, test mode off, all counters 0, synchronizers 0.
  - Outputs: display_out=000, seg_display=1001111 ("3").
  - Reset asserted mid-press discards the press. Release is synchronized, so no spurious press is generated if a button is held during release.

Test Plan:
- Reset: btn_reset=0 then 1 -> display_out=000, seg_display=1001111.
- Select and feed: 1-clk btn_salud pulse -> display_out=001, seg=1001111; 2nd pulse -> seg=1100110 (4); 3rd -> 1101101 (5); 4th -> stays 1101101.
- Switch and priority: btn_diversion pulse -> display_out=100, seg=1001111. btn_energia and btn_hambre pulsed together -> display_out=010.
- Test-mode decay: btn_test pulse with count_test=2 -> no change. Pulse with count_test=5, then 24 clks idle -> every level drops by 3, floored at 0. seg shows 0111111 for a level-3 need. With no need selected, display_out=111.
- Soft reset: count_reset=5 for 1 clk after feeding -> levels back to 3, display_out=000, test mode off (decay returns to DECAY_CYCLES).
- Feed/decay collision: in test mode, align a SALUD feed with a decay tick -> salud +1, other levels -1.
